// File: rtl/otter_wb_arbiter_pkg.sv
// Shared types for the register-file write arbiter: data width, register address width,
// and the {rd, data} record carried through the long-latency result FIFO.
package otter_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    localparam int REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/otter_wb_arbiter_if.sv
// Bundle between the WB stage / LL unit / hazard unit (master) and the write arbiter (slave),
// including the registered write port that feeds otter_rfile.
interface otter_wb_arbiter_if;
    import otter_wb_arbiter_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    logic                  ll_valid;
    logic                  ll_ready;
    logic [REG_ADDR_W-1:0] ll_rd;
    logic [XLEN-1:0]       ll_data;

    logic                  ll_issue_valid;
    logic [REG_ADDR_W-1:0] ll_issue_rd;

    logic                  w_en;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;

    logic [NREGS-1:0]      busy;
    logic                  stall_req;
    logic                  err;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output ll_valid, ll_rd, ll_data,
        output ll_issue_valid, ll_issue_rd,
        input  ll_ready, w_en, w_addr, w_data, busy, stall_req, err
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  ll_valid, ll_rd, ll_data,
        input  ll_issue_valid, ll_issue_rd,
        output ll_ready, w_en, w_addr, w_data, busy, stall_req, err
    );

endinterface

// File: rtl/otter_wb_arbiter_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, async active-high reset; read data is the head, no latency.
// Backpressure: push is ignored when full, pop ignored when empty; full/empty come from state only.
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/otter_wb_arbiter.sv
// Register-file write master merging WB-stage writes with FIFO-buffered long-latency results.
// One cycle input-to-w_en; LL side is valid/ready, WB side has none (stall_req asks upstream to hold).
module otter_wb_arbiter
    import otter_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    otter_wb_arbiter_if.slave  bus
);
    localparam int                CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STARVE_MAX - 1);

    wb_req_t               ll_in, head;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, wb_take, head_lose;

    logic                  w_en_q, w_en_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [XLEN-1:0]       w_data_q, w_data_d;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;

    assign ll_in.rd   = bus.ll_rd;
    assign ll_in.data = bus.ll_data;

    otter_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_ll_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (ll_in),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign push      = bus.ll_valid && !fifo_full;
    assign wb_take   = bus.wb_valid && !stall_q;
    assign pop       = !fifo_empty && (stall_q || !bus.wb_valid);
    assign head_lose = !fifo_empty && !pop;

    always_comb begin
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (wb_take) begin
            w_en_d   = (bus.wb_rd != '0);
            w_addr_d = bus.wb_rd;
            w_data_d = bus.wb_data;
        end else if (pop) begin
            w_en_d   = (head.rd != '0);
            w_addr_d = head.rd;
            w_data_d = head.data;
        end
    end

    // Starvation: a stalled head always drains, so stall lasts one cycle per episode.
    always_comb begin
        cnt_d = cnt_q;
        if (fifo_empty || pop) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
        stall_d = head_lose && (stall_q || (cnt_q == CNT_LAST));
        err_d   = err_q || (stall_q && bus.wb_valid);
    end

    // Clear on LL retire first so a same-cycle issue to that rd wins.
    always_comb begin
        busy_d = busy_q;
        if (pop && (head.rd != '0)) busy_d[head.rd] = 1'b0;
        if (bus.ll_issue_valid && (bus.ll_issue_rd != '0)) busy_d[bus.ll_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            busy_q   <= '0;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    assign bus.ll_ready  = !fifo_full;
    assign bus.w_en      = w_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.busy      = busy_q;
    assign bus.stall_req = stall_q;
    assign bus.err       = err_q;

endmodule
